// File: rtl/divisor_secuencial_if.sv
// Start/complete handshake and operand/result bus between the ALU and the sequential divider.
// Optional feature macro: DIVISOR_ZERO_DETECT_EN adds the div_zero flag.
interface divisor_secuencial_if #(
  parameter int WIDTH = 3
);
  logic             init;
  logic [WIDTH-1:0] DV;
  logic [WIDTH-1:0] DR;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;

`ifdef DIVISOR_ZERO_DETECT_EN
  logic             div_zero;

  modport master (output init, DV, DR,
                  input  quotient, remainder, done, busy, div_zero);
  modport slave  (input  init, DV, DR,
                  output quotient, remainder, done, busy, div_zero);
`else
  modport master (output init, DV, DR,
                  input  quotient, remainder, done, busy);
  modport slave  (input  init, DV, DR,
                  output quotient, remainder, done, busy);
`endif
endinterface

// File: rtl/divisor_secuencial.sv
// Restoring shift-and-subtract unsigned divider: DV / DR in 2*WIDTH cycles, result held until the next op.
// Optional feature macro: DIVISOR_ZERO_DETECT_EN (single-cycle divide-by-zero completion with div_zero flag).
module divisor_secuencial #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  divisor_secuencial_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH:0]   r, r_n, r_diff;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] d, d_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] quotient, quotient_n;
  logic [WIDTH-1:0] remainder, remainder_n;
  logic             done, done_n;
  logic             busy, busy_n;
`ifdef DIVISOR_ZERO_DETECT_EN
  logic             div_zero, div_zero_n;
`endif

  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  assign bus.done      = done;
  assign bus.busy      = busy;
`ifdef DIVISOR_ZERO_DETECT_EN
  assign bus.div_zero  = div_zero;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef DIVISOR_ZERO_DETECT_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      r         <= r_n;
      q         <= q_n;
      d         <= d_n;
      count     <= count_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      done      <= done_n;
      busy      <= busy_n;
`ifdef DIVISOR_ZERO_DETECT_EN
      div_zero  <= div_zero_n;
`endif
    end
  end

  // NOTE: every signal written here gets a hold default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_n     = state;
    r_n         = r;
    q_n         = q;
    d_n         = d;
    count_n     = count;
    quotient_n  = quotient;
    remainder_n = remainder;
    done_n      = done;
    busy_n      = busy;
`ifdef DIVISOR_ZERO_DETECT_EN
    div_zero_n  = div_zero;
`endif
    // Compared at WIDTH+1 bits so the shifted-in MSB never overflows the subtraction.
    r_diff      = r - {1'b0, d};

    case (state)
      IDLE: begin
        if (bus.init) begin
          q_n     = bus.DV;
          d_n     = bus.DR;
          r_n     = '0;
          count_n = CW'(WIDTH);
          busy_n  = 1'b1;
          state_n = SHIFT;
`ifdef DIVISOR_ZERO_DETECT_EN
          div_zero_n = 1'b0;
          if (bus.DR == '0) begin
            quotient_n  = '1;
            remainder_n = bus.DV;
            div_zero_n  = 1'b1;
            done_n      = 1'b1;
            state_n     = DONE;
          end
`endif
        end
      end

      SHIFT: begin
        {r_n, q_n} = {r[WIDTH-1:0], q, 1'b0};
        state_n    = SUB;
      end

      SUB: begin
        if (r >= {1'b0, d}) begin
          r_n    = r_diff;
          q_n[0] = 1'b1;
        end else begin
          q_n[0] = 1'b0;
        end
        count_n = count - CW'(1);
        if (count == CW'(1)) begin
          quotient_n  = q_n;
          remainder_n = r_n[WIDTH-1:0];
          done_n      = 1'b1;
          state_n     = DONE;
        end else begin
          state_n = SHIFT;
        end
      end

      DONE: begin
        done_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
